// File: rtl/uart_pkg.sv
// Shared UART definitions: baud codes, divisor mapping, FSM states and frame length.
// Build option: define UART_PARITY_EN for 8E1 framing; the default is 8N1.
package uart_pkg;

  localparam logic [2:0] BAUD_300    = 3'd0;
  localparam logic [2:0] BAUD_1200   = 3'd1;
  localparam logic [2:0] BAUD_4800   = 3'd2;
  localparam logic [2:0] BAUD_9600   = 3'd3;
  localparam logic [2:0] BAUD_19200  = 3'd4;
  localparam logic [2:0] BAUD_38400  = 3'd5;
  localparam logic [2:0] BAUD_57600  = 3'd6;
  localparam logic [2:0] BAUD_115200 = 3'd7;

`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_e;

  // Clock cycles per bit, truncated; only ever evaluated at elaboration.
  function automatic logic [17:0] baud_div(input logic [2:0] code, input int unsigned clk_freq);
    int unsigned rate;
    rate = 115200;
    case (code)
      BAUD_300:    rate = 300;
      BAUD_1200:   rate = 1200;
      BAUD_4800:   rate = 4800;
      BAUD_9600:   rate = 9600;
      BAUD_19200:  rate = 19200;
      BAUD_38400:  rate = 38400;
      BAUD_57600:  rate = 57600;
      default:     rate = 115200;
    endcase
    return 18'(clk_freq / rate);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period divisor: emits a one-cycle tick every DIV cycles while running.
// A restart clears the count, or preloads half a period for mid-bit sampling.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] code,
  input  logic       run,
  input  logic       restart,
  input  logic       restart_half,
  output logic       tick
);

  localparam logic [17:0] DIV_TABLE [8] = '{
    baud_div(3'd0, CLK_FREQ), baud_div(3'd1, CLK_FREQ),
    baud_div(3'd2, CLK_FREQ), baud_div(3'd3, CLK_FREQ),
    baud_div(3'd4, CLK_FREQ), baud_div(3'd5, CLK_FREQ),
    baud_div(3'd6, CLK_FREQ), baud_div(3'd7, CLK_FREQ)
  };

  logic [17:0] cnt_q, cnt_d;
  logic [17:0] div;

  always_comb begin
    div   = DIV_TABLE[code];
    tick  = run && !restart && (cnt_q == div - 18'd1);
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = restart_half ? (div >> 1) : 18'd0;
    end else if (!run || tick) begin
      cnt_d = 18'd0;
    end else begin
      cnt_d = cnt_q + 18'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 18'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit FSM: one byte per accepted write, shifted out LSB first at the latched rate.
// Build option: UART_PARITY_EN inserts an even parity bit before the stop bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY
);

  tx_state_e   state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [2:0]  baud_q, baud_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        accept;
  logic        tick;
`ifdef UART_PARITY_EN
  logic        parity_q, parity_d;
`endif

  uart_bit_timer #(.CLK_FREQ(CLK_FREQ)) u_bit_timer (
    .clk          (clk),
    .reset        (reset),
    .code         (baud_q),
    .run          (busy_q),
    .restart      (accept),
    .restart_half (1'b0),
    .tick         (tick)
  );

  // Outputs are computed alongside the next state so the line changes on the same edge as the FSM.
  always_comb begin
    accept    = Tx_WR && Tx_EN && !busy_q;
    state_d   = state_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    baud_d    = baud_q;
    txd_d     = txd_q;
    busy_d    = busy_q;
`ifdef UART_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (accept) begin
          state_d   = ST_START;
          data_d    = Tx_DATA;
          baud_d    = baud_select;
          bit_idx_d = 3'd0;
          txd_d     = 1'b0;
          busy_d    = 1'b1;
`ifdef UART_PARITY_EN
          parity_d  = ^Tx_DATA;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          txd_d   = data_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
            txd_d   = parity_q;
`else
            state_d = ST_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            data_d    = {1'b0, data_q[7:1]};
            txd_d     = data_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      data_q    <= 8'd0;
      bit_idx_q <= 3'd0;
      baud_q    <= 3'd0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      baud_q    <= baud_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
`ifdef UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter at 50 MHz; follows UART_PARITY_EN for the expected frame.
module tb_uart_transmitter;
  import uart_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         limit;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [2:0] baud_select;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       TxD;
  logic       Tx_BUSY;

  int   n_tests;
  int   n_fail;
  exp_t sb[$];
  bit   mon_en;
  bit   mon_active;
  bit   busy_prev;
  int   divs [8];

  uart_transmitter #(.CLK_FREQ(50000000)) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .Tx_DATA     (Tx_DATA),
    .TxD         (TxD),
    .Tx_BUSY     (Tx_BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line bits in transmit order: start, data LSB first, optional even parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_PARITY_EN
    f[9]   = ^d;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Called just after a rising edge; the write strobe is held for exactly one edge.
  task automatic applyStimulus(input logic [7:0] data, input logic [2:0] code, input logic en,
                               input bit expect_accept, input int limit);
    exp_t e;
    Tx_DATA     = data;
    baud_select = code;
    Tx_EN       = en;
    Tx_WR       = 1'b1;
    if (expect_accept) begin
      e.data  = data;
      e.div   = divs[code];
      e.limit = limit;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    Tx_WR = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (Tx_BUSY !== 1'b0 && n < 10000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 10000) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: busy still %b after %0d cycles, expected 0", name, Tx_BUSY, n);
    end
  endtask

  task automatic resetPulse(input string name);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({name, "_txd"}, TxD, 1'b1);
    checkOutput({name, "_busy"}, Tx_BUSY, 1'b0);
    reset = 1'b0;
  endtask

  // Monitor: on each frame start, pop the expected byte and verify every bit level and the busy length.
  initial begin : monitor
    exp_t        e;
    logic [10:0] bits;
    int          total;
    int          lim;
    int          idx;
    int          n;
    bit          ok;
    logic        bad_val;
    busy_prev  = 1'b0;
    mon_active = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && Tx_BUSY === 1'b1 && !busy_prev) begin
        mon_active = 1'b1;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_frame: got frame start with TxD=%b, expected no frame", TxD);
          n = 0;
          while (Tx_BUSY !== 1'b0 && n < 200000) begin
            @(negedge clk);
            n++;
          end
        end else begin
          e       = sb.pop_front();
          bits    = frame_bits(e.data);
          total   = FRAME_BITS * e.div;
          lim     = (e.limit == 0) ? total : e.limit;
          ok      = 1'b1;
          bad_val = 1'b0;
          for (int c = 0; c < lim; c++) begin
            if (c > 0) @(negedge clk);
            idx = c / e.div;
            if (c % e.div == 0) begin
              ok      = 1'b1;
              bad_val = 1'b0;
            end
            if (ok && (TxD !== bits[idx] || Tx_BUSY !== 1'b1)) begin
              ok      = 1'b0;
              bad_val = TxD;
            end
            if ((c % e.div == e.div - 1) || (c == lim - 1)) begin
              n_tests++;
              if (!ok) begin
                n_fail++;
                $display("[TB] FAIL frame_%02h_bit%0d: got %b, expected %b with busy high",
                         e.data, idx, bad_val, bits[idx]);
              end
            end
          end
          if (e.limit == 0) begin
            @(negedge clk);
            n_tests++;
            if (Tx_BUSY !== 1'b0 || TxD !== 1'b1) begin
              n_fail++;
              $display("[TB] FAIL frame_%02h_busy_len: got busy=%b txd=%b after %0d cycles, expected busy=0 txd=1",
                       e.data, Tx_BUSY, TxD, total);
            end
          end else begin
            n = 0;
            while (Tx_BUSY !== 1'b0 && n < 10000) begin
              @(negedge clk);
              n++;
            end
            n_tests++;
            if (n >= 10000) begin
              n_fail++;
              $display("[TB] FAIL frame_%02h_abort: got busy=%b, expected 0 after reset", e.data, Tx_BUSY);
            end
          end
        end
        mon_active = 1'b0;
      end
      busy_prev = (Tx_BUSY === 1'b1);
    end
  end

  initial begin : stimulus
    int n;
    divs        = '{166666, 41666, 10416, 5208, 2604, 1302, 868, 434};
    n_tests     = 0;
    n_fail      = 0;
    mon_en      = 1'b0;
    reset       = 1'b1;
    Tx_EN       = 1'b1;
    Tx_WR       = 1'b0;
    Tx_DATA     = 8'h00;
    baud_select = 3'd7;

    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("reset_txd", TxD, 1'b1);
      checkOutput("reset_busy", Tx_BUSY, 1'b0);
    end
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      checkOutput("idle_txd", TxD, 1'b1);
      checkOutput("idle_busy", Tx_BUSY, 1'b0);
    end

    // 0xA5 at 115200; a mid-frame 0x3C write and an enable drop must not disturb it.
    applyStimulus(8'hA5, 3'd7, 1'b1, 1'b1, 0);
    checkOutput("a5_start_txd", TxD, 1'b0);
    checkOutput("a5_start_busy", Tx_BUSY, 1'b1);
    repeat (1000) @(posedge clk);
    #1;
    applyStimulus(8'h3C, 3'd7, 1'b1, 1'b0, 0);
    Tx_EN = 1'b0;
    waitIdle("a5_idle");

    // Write with the transmitter disabled is dropped.
    applyStimulus(8'h55, 3'd7, 1'b0, 1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("disabled_busy", Tx_BUSY, 1'b0);
    checkOutput("disabled_txd", TxD, 1'b1);
    Tx_EN = 1'b1;

    // 0x07 (parity bit 1 when built with parity), then back-to-back 0x81 and 0x5A.
    applyStimulus(8'h07, 3'd7, 1'b1, 1'b1, 0);
    waitIdle("x07_idle");
    applyStimulus(8'h81, 3'd7, 1'b1, 1'b1, 0);
    checkOutput("b2b_busy", Tx_BUSY, 1'b1);
    checkOutput("b2b_txd", TxD, 1'b0);
    waitIdle("x81_idle");
    applyStimulus(8'h5A, 3'd7, 1'b1, 1'b1, 0);
    repeat (500) @(posedge clk);
    #1;
    baud_select = 3'd0;
    waitIdle("x5a_idle");

    // Next frame picks up code 0: the start bit outlasts many 115200 bit periods.
    applyStimulus(8'hC3, 3'd0, 1'b1, 1'b1, 2000);
    repeat (2100) @(posedge clk);
    #1;
    resetPulse("slow_reset");

    // Reset during data bit 4, then a clean 0xFF frame.
    applyStimulus(8'h96, 3'd7, 1'b1, 1'b1, 5 * 434);
    repeat (5 * 434 + 200) @(posedge clk);
    #1;
    resetPulse("bit4_reset");
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(8'hFF, 3'd7, 1'b1, 1'b1, 0);
    waitIdle("xff_idle");

    n = 0;
    while ((sb.size() != 0 || mon_active) && n < 10000) begin
      @(posedge clk);
      n++;
    end
    repeat (10) @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending frames, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
